// File: rtl/discrete_channel_mixer_if.sv
// Channel mixer bus: sample strobe, packed channel inputs and mixed output.
// The master drives the channels; the slave (mixer) returns the sample and flags.
interface discrete_channel_mixer_if #(
    parameter int NUM_CH = 4
) ();
    logic                   audio_clk_en;
    logic [NUM_CH*16-1:0]   ch_in;
    logic [NUM_CH*8-1:0]    ch_gain;
    logic [NUM_CH-1:0]      ch_mute;
    logic                   clear_flags;
    logic [15:0]            out;
    logic                   out_valid;
    logic                   busy;
    logic                   clip;
    logic                   overrun;

    modport master (
        output audio_clk_en, ch_in, ch_gain, ch_mute, clear_flags,
        input  out, out_valid, busy, clip, overrun
    );

    modport slave (
        input  audio_clk_en, ch_in, ch_gain, ch_mute, clear_flags,
        output out, out_valid, busy, clip, overrun
    );
endinterface

// File: rtl/discrete_channel_mixer.sv
// Sample-rate channel mixer: snapshot, time-shared gain MAC,
// floor shift and saturation to one signed 16-bit sample.
module discrete_channel_mixer #(
    parameter int NUM_CH     = 4,
    parameter int GAIN_SHIFT = 7
) (
    input  logic                  clk,
    input  logic                  I_RST,
    discrete_channel_mixer_if.slave bus
);
    localparam int IW = $clog2(NUM_CH);
    localparam int AW = 25 + $clog2(NUM_CH);
    localparam logic [IW-1:0] LAST = IW'(NUM_CH - 1);
    localparam logic signed [AW-1:0] MAXV = AW'(32767);
    localparam logic signed [AW-1:0] MINV = AW'(-32768);

    typedef enum logic [1:0] {
        S_IDLE, S_MAC, S_SAT, S_OUT
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_busy;
    logic                    w_valid;
    logic                    w_start;

    logic [NUM_CH*16-1:0]    r_snap_in;
    logic [NUM_CH*8-1:0]     r_snap_gain;
    logic [NUM_CH-1:0]       r_snap_mute;
    logic signed [AW-1:0]    r_acc;
    logic [IW-1:0]           r_idx;
    logic [15:0]             r_out;
    logic                    r_clip;
    logic                    r_ovr;

    logic signed [15:0]      w_in;
    logic [7:0]              w_gain;
    logic                    w_mute;
    logic signed [24:0]      w_prod;
    logic signed [24:0]      w_term;
    logic signed [AW-1:0]    w_ext;
    logic signed [AW-1:0]    w_shift;
    logic [15:0]             w_sat;
    logic                    w_clamp;
    logic                    w_clip_set;
    logic                    w_ovr_set;

    // State register; reset abandons any mix in flight.
    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state: one capture clk, NUM_CH MAC clks, then SAT and OUT.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (bus.audio_clk_en) w_next = S_MAC;
            S_MAC:  if (r_idx == LAST)    w_next = S_SAT;
            S_SAT:  w_next = S_OUT;
            S_OUT:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM-decoded outputs and strobe qualification.
    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_valid   = (r_state == S_OUT);
        w_start   = bus.audio_clk_en && !w_busy;
        w_ovr_set = bus.audio_clk_en && w_busy;
    end

    // Current channel through the shared 16x9 signed multiplier.
    always_comb begin
        w_in   = r_snap_in[r_idx*16 +: 16];
        w_gain = r_snap_gain[r_idx*8 +: 8];
        w_mute = r_snap_mute[r_idx];
        w_prod = w_in * $signed({1'b0, w_gain});
        w_term = w_mute ? 25'sd0 : w_prod;
        w_ext  = {{(AW-25){w_term[24]}}, w_term};
    end

    // Floor shift out of the gain fraction, then clamp to 16 bits.
    always_comb begin
        w_shift = r_acc >>> GAIN_SHIFT;
        w_sat   = w_shift[15:0];
        w_clamp = 1'b0;
        if (w_shift > MAXV) begin
            w_sat   = 16'h7fff;
            w_clamp = 1'b1;
        end else if (w_shift < MINV) begin
            w_sat   = 16'h8000;
            w_clamp = 1'b1;
        end
        w_clip_set = (r_state == S_SAT) && w_clamp;
    end

    // Snapshot capture, accumulation and output sample register.
    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            r_snap_in   <= '0;
            r_snap_gain <= '0;
            r_snap_mute <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_out       <= '0;
        end else begin
            if (w_start) begin
                r_snap_in   <= bus.ch_in;
                r_snap_gain <= bus.ch_gain;
                r_snap_mute <= bus.ch_mute;
                r_acc       <= '0;
                r_idx       <= '0;
            end else if (r_state == S_MAC) begin
                r_acc <= r_acc + w_ext;
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == S_SAT) r_out <= w_sat;
        end
    end

    // Sticky flags; a set event beats a simultaneous clear.
    always_ff @(posedge clk or posedge I_RST) begin
        if (I_RST) begin
            r_clip <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_clip_set)           r_clip <= 1'b1;
            else if (bus.clear_flags) r_clip <= 1'b0;
            if (w_ovr_set)            r_ovr  <= 1'b1;
            else if (bus.clear_flags) r_ovr  <= 1'b0;
        end
    end

    assign bus.out       = r_out;
    assign bus.out_valid = w_valid;
    assign bus.busy      = w_busy;
    assign bus.clip      = r_clip;
    assign bus.overrun   = r_ovr;
endmodule
